// File: rtl/time_keeper_pkg.sv
// Shared types, widths and helpers for the timekeeping core.
package time_keeper_pkg;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  localparam int unsigned MAX_SEC         = 59;
  localparam int unsigned MAX_MIN         = 59;
  localparam int unsigned HOURS_RESET_12H = 12;
  localparam int unsigned HOURS_RESET_24H = 0;

  typedef enum logic [1:0] {
    COUNT       = 2'd0,
    SET_HOURS   = 2'd1,
    SET_MINUTES = 2'd2
  } state_t;

  // Payload driven to the display mux.
  typedef struct packed {
    logic              am_pm;
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  mins;
  } disp_bus_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hours;
    logic              am_pm;
  } hour_t;

  // One hour step, including the AM/PM rule for the selected format.
  function automatic hour_t hour_inc(input hour_t cur, input logic mode_24h);
    hour_t nxt;
    nxt = cur;
    if (mode_24h) begin
      nxt.hours = (cur.hours == HOUR_W'(23)) ? HOUR_W'(0) : cur.hours + HOUR_W'(1);
      nxt.am_pm = (nxt.hours >= HOUR_W'(12));
    end else begin
      nxt.hours = (cur.hours == HOUR_W'(12)) ? HOUR_W'(1) : cur.hours + HOUR_W'(1);
      if (cur.hours == HOUR_W'(11)) nxt.am_pm = ~cur.am_pm;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/time_keeper_tick_gen.sv
// Terminal-count divider: counts 0..PERIOD-1 while enabled, tick_c_o flags the terminal cycle.
module time_keeper_tick_gen #(
  parameter int unsigned PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_c_o
);

  localparam int unsigned       CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable, wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick_c_o = en_i & ~clr_i & (cnt_q == LAST);

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/time_keeper_core.sv
// Timekeeping core: prescaled h:m:s counter, 12h/24h format, set-mode FSM with auto-repeat.
// Optional alarm compare is built when ALARM_MATCH_EN is defined.
module time_keeper_core
  import time_keeper_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter bit          MODE_24H      = 1'b0,
  parameter int unsigned REPEAT_CYCLES = 25_000_000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              SET_TIME,
  input  logic              HRS_BTN,
  input  logic              MINS_BTN,
`ifdef ALARM_MATCH_EN
  input  logic              ALARM_SET,
  input  logic [HOUR_W-1:0] ALARM_HOURS,
  input  logic [MIN_W-1:0]  ALARM_MINS,
  input  logic              ALARM_AM_PM,
  output logic              ALARM_OUT,
`endif
  output logic [SEC_W-1:0]  SECS_OUT,
  output logic [MIN_W-1:0]  MINS_OUT,
  output logic [HOUR_W-1:0] HOURS_OUT,
  output logic              AM_PM_OUT,
  output logic              SEC_PULSE,
  output logic [11:0]       DISPLAY_BUS
);

  localparam logic [HOUR_W-1:0] HOURS_RST =
    MODE_24H ? HOUR_W'(HOURS_RESET_24H) : HOUR_W'(HOURS_RESET_12H);

  state_t           state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic [MIN_W-1:0] mins_q, mins_d;
  hour_t            hr_q, hr_d;
  logic             pulse_q, pulse_d;
  disp_bus_t        disp_q, disp_d;

  logic hrs_combo_c, mins_combo_c, enter_c, rep_run_c;
  logic presc_en_c, presc_clr_c, presc_tick_c, rep_tick_c;
  logic inc_hr_c, inc_min_c;

  assign hrs_combo_c  = SET_TIME & HRS_BTN & ~MINS_BTN;
  assign mins_combo_c = SET_TIME & MINS_BTN & ~HRS_BTN;
  assign enter_c      = (state_q == COUNT) & (hrs_combo_c | mins_combo_c);
  assign presc_en_c   = ENABLE & (state_q == COUNT) & ~enter_c;
  assign presc_clr_c  = (state_q != COUNT) | enter_c;
  assign rep_run_c    = ((state_q == SET_HOURS)   & hrs_combo_c) |
                        ((state_q == SET_MINUTES) & mins_combo_c);

  time_keeper_tick_gen #(.PERIOD(TICKS_PER_SEC)) u_presc (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .clr_i    (presc_clr_c),
    .en_i     (presc_en_c),
    .tick_c_o (presc_tick_c)
  );

  time_keeper_tick_gen #(.PERIOD(REPEAT_CYCLES)) u_repeat (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .clr_i    (~rep_run_c),
    .en_i     (rep_run_c),
    .tick_c_o (rep_tick_c)
  );

  // Set-mode FSM: one increment on entry, then one per repeat period while held.
  always_comb begin
    state_d   = state_q;
    inc_hr_c  = 1'b0;
    inc_min_c = 1'b0;
    case (state_q)
      COUNT: begin
        if (hrs_combo_c) begin
          state_d  = SET_HOURS;
          inc_hr_c = 1'b1;
        end else if (mins_combo_c) begin
          state_d   = SET_MINUTES;
          inc_min_c = 1'b1;
        end
      end
      SET_HOURS: begin
        if (!hrs_combo_c) state_d = COUNT;
        else              inc_hr_c = rep_tick_c;
      end
      SET_MINUTES: begin
        if (!mins_combo_c) state_d = COUNT;
        else               inc_min_c = rep_tick_c;
      end
      default: state_d = COUNT;
    endcase
  end

  // Time datapath: second ticks carry through; set-mode minute edits never carry into hours.
  always_comb begin
    secs_d  = secs_q;
    mins_d  = mins_q;
    hr_d    = hr_q;
    pulse_d = 1'b0;
    if (enter_c) secs_d = '0;
    if (presc_tick_c) begin
      pulse_d = 1'b1;
      if (secs_q == SEC_W'(MAX_SEC)) begin
        secs_d = '0;
        if (mins_q == MIN_W'(MAX_MIN)) begin
          mins_d = '0;
          hr_d   = hour_inc(hr_q, MODE_24H);
        end else begin
          mins_d = mins_q + MIN_W'(1);
        end
      end else begin
        secs_d = secs_q + SEC_W'(1);
      end
    end
    if (inc_min_c) mins_d = (mins_q == MIN_W'(MAX_MIN)) ? '0 : mins_q + MIN_W'(1);
    if (inc_hr_c)  hr_d   = hour_inc(hr_q, MODE_24H);
    disp_d = '{am_pm: hr_d.am_pm, hours: hr_d.hours, mins: mins_d};
  end

  // State and time registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= COUNT;
      secs_q  <= '0;
      mins_q  <= '0;
      hr_q    <= '{hours: HOURS_RST, am_pm: 1'b0};
      pulse_q <= 1'b0;
      disp_q  <= '{am_pm: 1'b0, hours: HOURS_RST, mins: MIN_W'(0)};
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      mins_q  <= mins_d;
      hr_q    <= hr_d;
      pulse_q <= pulse_d;
      disp_q  <= disp_d;
    end
  end

  assign SECS_OUT    = secs_q;
  assign MINS_OUT    = mins_q;
  assign HOURS_OUT   = hr_q.hours;
  assign AM_PM_OUT   = hr_q.am_pm;
  assign SEC_PULSE   = pulse_q;
  assign DISPLAY_BUS = disp_q;

`ifdef ALARM_MATCH_EN
  disp_bus_t alarm_val_q;
  logic      alarm_set_q, alarm_q;
  logic      alarm_hit_c;

  assign alarm_hit_c = presc_tick_c & alarm_set_q & (secs_d == '0) & (disp_d == alarm_val_q);

  // Alarm: latch compare value on ALARM_SET rise, fire on a counted tick reaching HH:MM:00.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      alarm_set_q <= 1'b0;
      alarm_val_q <= '0;
      alarm_q     <= 1'b0;
    end else begin
      alarm_set_q <= ALARM_SET;
      if (ALARM_SET & ~alarm_set_q)
        alarm_val_q <= '{am_pm: ALARM_AM_PM, hours: ALARM_HOURS, mins: ALARM_MINS};
      if (!ALARM_SET)       alarm_q <= 1'b0;
      else if (alarm_hit_c) alarm_q <= 1'b1;
    end
  end

  assign ALARM_OUT = alarm_q;
`endif

endmodule

// File: tb/tb_time_keeper_core.sv
// Bench for time_keeper_core: 12h and 24h instances share stimulus; model tracks seconds-of-day.
module tb_time_keeper_core;

  localparam int unsigned TPS = 4;
  localparam int unsigned RC  = 3;

  logic CLK = 1'b0;
  logic RESET, ENABLE, SET_TIME, HRS_BTN, MINS_BTN;

  logic [5:0]  sec12, min12, sec24, min24;
  logic [4:0]  hr12, hr24;
  logic        pm12, pm24, pul12, pul24;
  logic [11:0] bus12, bus24;

  time_keeper_core #(.TICKS_PER_SEC(TPS), .MODE_24H(1'b0), .REPEAT_CYCLES(RC)) dut12 (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SET_TIME(SET_TIME),
    .HRS_BTN(HRS_BTN), .MINS_BTN(MINS_BTN),
    .SECS_OUT(sec12), .MINS_OUT(min12), .HOURS_OUT(hr12), .AM_PM_OUT(pm12),
    .SEC_PULSE(pul12), .DISPLAY_BUS(bus12)
  );

  time_keeper_core #(.TICKS_PER_SEC(TPS), .MODE_24H(1'b1), .REPEAT_CYCLES(RC)) dut24 (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SET_TIME(SET_TIME),
    .HRS_BTN(HRS_BTN), .MINS_BTN(MINS_BTN),
    .SECS_OUT(sec24), .MINS_OUT(min24), .HOURS_OUT(hr24), .AM_PM_OUT(pm24),
    .SEC_PULSE(pul24), .DISPLAY_BUS(bus24)
  );

  wire [30:0] obs12 = {sec12, min12, hr12, pm12, pul12, bus12};
  wire [30:0] obs24 = {sec24, min24, hr24, pm24, pul24, bus24};

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: time of day in seconds, mode (0 count, 1 set hours, 2 set minutes),
  // enabled cycles since last prescaler restart, held cycles since last repeat.
  int tod, mmode, pres, rep;
  bit epulse;

  task automatic model_reset();
    tod = 0; mmode = 0; pres = 0; rep = 0; epulse = 1'b0;
  endtask

  task automatic min_inc();
    if (((tod / 60) % 60) == 59) tod -= 59 * 60;
    else                         tod += 60;
  endtask

  task automatic model_step();
    bit hc, mc;
    if (RESET) begin
      model_reset();
      return;
    end
    hc = SET_TIME && HRS_BTN && !MINS_BTN;
    mc = SET_TIME && MINS_BTN && !HRS_BTN;
    epulse = 1'b0;
    case (mmode)
      0: begin
        if (hc || mc) begin
          tod -= tod % 60;
          pres = 0; rep = 0;
          if (hc) begin tod = (tod + 3600) % 86400; mmode = 1; end
          else    begin min_inc(); mmode = 2; end
        end else if (ENABLE) begin
          pres++;
          if (pres == TPS) begin pres = 0; tod = (tod + 1) % 86400; epulse = 1'b1; end
        end
      end
      1: begin
        if (hc) begin
          rep++;
          if (rep == RC) begin rep = 0; tod = (tod + 3600) % 86400; end
        end else begin mmode = 0; pres = 0; rep = 0; end
      end
      default: begin
        if (mc) begin
          rep++;
          if (rep == RC) begin rep = 0; min_inc(); end
        end else begin mmode = 0; pres = 0; rep = 0; end
      end
    endcase
  endtask

  function automatic logic [30:0] exp_vec(input bit m24);
    int h, mn, sc, hd;
    bit pm;
    h  = tod / 3600;
    mn = (tod / 60) % 60;
    sc = tod % 60;
    pm = (h >= 12);
    hd = m24 ? h : (((h % 12) == 0) ? 12 : (h % 12));
    return {6'(sc), 6'(mn), 5'(hd), pm, epulse, pm, 5'(hd), 6'(mn)};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic nav_hour(input int target);
    int guard;
    guard = 0;
    ENABLE = 1'b1; SET_TIME = 1'b1; HRS_BTN = 1'b1; MINS_BTN = 1'b0;
    while ((tod / 3600) != target && guard < 400) begin cyc(); guard++; end
    SET_TIME = 1'b0; HRS_BTN = 1'b0;
    cyc();
    total++;
    if (guard >= 400 || {obs12, obs24} !== {exp_vec(0), exp_vec(1)}) begin
      bad++;
      $display("FAIL nav_hour(%0d) got=%h/%h want=%h/%h", target, obs12, obs24, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic nav_min(input int target);
    int guard;
    guard = 0;
    ENABLE = 1'b1; SET_TIME = 1'b1; MINS_BTN = 1'b1; HRS_BTN = 1'b0;
    while (((tod / 60) % 60) != target && guard < 400) begin cyc(); guard++; end
    SET_TIME = 1'b0; MINS_BTN = 1'b0;
    cyc();
    total++;
    if (guard >= 400 || {obs12, obs24} !== {exp_vec(0), exp_vec(1)}) begin
      bad++;
      $display("FAIL nav_min(%0d) got=%h/%h want=%h/%h", target, obs12, obs24, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic run_secs(input int target);
    int guard;
    guard = 0;
    ENABLE = 1'b1; SET_TIME = 1'b0; HRS_BTN = 1'b0; MINS_BTN = 1'b0;
    while ((tod % 60) != target && guard < 400) begin cyc(); guard++; end
    total++;
    if (guard >= 400 || {obs12, obs24} !== {exp_vec(0), exp_vec(1)}) begin
      bad++;
      $display("FAIL run_secs(%0d) got=%h/%h want=%h/%h", target, obs12, obs24, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic wait_ticks(input int n);
    int guard, cnt;
    guard = 0; cnt = 0;
    while (cnt < n && guard < 100) begin
      cyc();
      if (epulse) cnt++;
      guard++;
    end
    total++;
    if (guard >= 100 || {obs12, obs24} !== {exp_vec(0), exp_vec(1)}) begin
      bad++;
      $display("FAIL wait_ticks(%0d) got=%h/%h want=%h/%h", n, obs12, obs24, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; ENABLE = 1'b1; SET_TIME = 1'b0; HRS_BTN = 1'b0; MINS_BTN = 1'b0;
    model_reset();
    repeat (2) cyc();
    total++;
    if ({hr12, pm12, min12, sec12, pul12} !== {5'd12, 1'b0, 6'd0, 6'd0, 1'b0}) begin
      bad++; $display("FAIL reset_12h got=%h want=%h", {hr12, pm12, min12, sec12, pul12}, {5'd12, 1'b0, 12'd0, 1'b0});
    end
    total++;
    if ({obs12, obs24} !== {exp_vec(0), exp_vec(1)}) begin
      bad++; $display("FAIL reset_model got=%h/%h want=%h/%h", obs12, obs24, exp_vec(0), exp_vec(1));
    end
    RESET = 1'b0;
    repeat (3) cyc();
    total++;
    if ({sec12, pul12} !== {6'd0, 1'b0}) begin
      bad++; $display("FAIL early_tick got=%h want=%h", {sec12, pul12}, 7'd0);
    end
    cyc();
    total++;
    if ({sec12, pul12, bus12} !== {6'd1, 1'b1, 12'h300}) begin
      bad++; $display("FAIL first_tick got=%h want=%h", {sec12, pul12, bus12}, {6'd1, 1'b1, 12'h300});
    end
    total++;
    if ({obs12, obs24} !== {exp_vec(0), exp_vec(1)}) begin
      bad++; $display("FAIL first_tick_model got=%h/%h want=%h/%h", obs12, obs24, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic test_noon_and_one();
    nav_hour(11);
    nav_min(59);
    run_secs(58);
    wait_ticks(2);
    total++;
    if ({hr12, pm12, min12, sec12, hr24, pm24} !== {5'd12, 1'b1, 6'd0, 6'd0, 5'd12, 1'b1}) begin
      bad++; $display("FAIL noon got=%h want=%h", {hr12, pm12, min12, sec12, hr24, pm24}, {5'd12, 1'b1, 12'd0, 5'd12, 1'b1});
    end
    nav_min(59);
    run_secs(59);
    wait_ticks(1);
    total++;
    if ({hr12, pm12, min12, sec12, hr24, pm24} !== {5'd1, 1'b1, 6'd0, 6'd0, 5'd13, 1'b1}) begin
      bad++; $display("FAIL one_pm got=%h want=%h", {hr12, pm12, min12, sec12, hr24, pm24}, {5'd1, 1'b1, 12'd0, 5'd13, 1'b1});
    end
  endtask

  task automatic test_midnight();
    nav_hour(23);
    nav_min(59);
    run_secs(59);
    wait_ticks(1);
    total++;
    if ({hr24, pm24, min24, sec24, hr12, pm12} !== {5'd0, 1'b0, 6'd0, 6'd0, 5'd12, 1'b0}) begin
      bad++; $display("FAIL midnight got=%h want=%h", {hr24, pm24, min24, sec24, hr12, pm12}, {5'd0, 1'b0, 12'd0, 5'd12, 1'b0});
    end
  endtask

  task automatic test_set_minutes();
    nav_hour(10);
    nav_min(58);
    run_secs(30);
    SET_TIME = 1'b1; MINS_BTN = 1'b1; HRS_BTN = 1'b0;
    repeat (3 * RC) cyc();
    SET_TIME = 1'b0; MINS_BTN = 1'b0;
    cyc();
    total++;
    if ({hr12, pm12, min12, sec12} !== {5'd10, 1'b0, 6'd1, 6'd0}) begin
      bad++; $display("FAIL set_minutes got=%h want=%h", {hr12, pm12, min12, sec12}, {5'd10, 1'b0, 6'd1, 6'd0});
    end
    total++;
    if ({obs12, obs24} !== {exp_vec(0), exp_vec(1)}) begin
      bad++; $display("FAIL set_minutes_model got=%h/%h want=%h/%h", obs12, obs24, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic test_both_buttons();
    logic [4:0] hold_hr;
    logic [5:0] hold_min;
    hold_hr = hr12; hold_min = min12;
    SET_TIME = 1'b1; HRS_BTN = 1'b1; MINS_BTN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      total++;
      if ({obs12, obs24} !== {exp_vec(0), exp_vec(1)}) begin
        bad++; $display("FAIL both_buttons[%0d] got=%h/%h want=%h/%h", i, obs12, obs24, exp_vec(0), exp_vec(1));
      end
    end
    total++;
    if ({hr12, min12} !== {hold_hr, hold_min}) begin
      bad++; $display("FAIL both_buttons_hm got=%h want=%h", {hr12, min12}, {hold_hr, hold_min});
    end
    SET_TIME = 1'b0; HRS_BTN = 1'b0; MINS_BTN = 1'b0;
  endtask

  task automatic test_enable_hold();
    logic [5:0] hold_sec;
    hold_sec = sec12;
    ENABLE = 1'b0;
    repeat (10 * TPS) cyc();
    total++;
    if (sec12 !== hold_sec) begin
      bad++; $display("FAIL enable_hold got=%0d want=%0d", sec12, hold_sec);
    end
    total++;
    if ({obs12, obs24} !== {exp_vec(0), exp_vec(1)}) begin
      bad++; $display("FAIL enable_hold_model got=%h/%h want=%h/%h", obs12, obs24, exp_vec(0), exp_vec(1));
    end
    ENABLE = 1'b1;
  endtask

  task automatic test_reset_mid_set();
    SET_TIME = 1'b1; HRS_BTN = 1'b1; MINS_BTN = 1'b0;
    repeat (5) cyc();
    RESET = 1'b1;
    model_reset();
    #1;
    total++;
    if ({hr12, pm12, min12, sec12, pul12, hr24} !== {5'd12, 1'b0, 6'd0, 6'd0, 1'b0, 5'd0}) begin
      bad++; $display("FAIL reset_mid_set got=%h want=%h", {hr12, pm12, min12, sec12, pul12, hr24}, {5'd12, 14'd0});
    end
    SET_TIME = 1'b0; HRS_BTN = 1'b0;
    cyc();
    RESET = 1'b0;
    repeat (TPS) cyc();
    total++;
    if ({hr12, sec12, pul12} !== {5'd12, 6'd1, 1'b1}) begin
      bad++; $display("FAIL count_after_reset got=%h want=%h", {hr12, sec12, pul12}, {5'd12, 6'd1, 1'b1});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      ENABLE = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) SET_TIME = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) HRS_BTN  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) MINS_BTN = 1'($urandom_range(0, 1));
      RESET = ($urandom_range(0, 399) == 0);
      cyc();
      total++;
      if ({obs12, obs24} !== {exp_vec(0), exp_vec(1)}) begin
        bad++; $display("FAIL random[%0d] got=%h/%h want=%h/%h", i, obs12, obs24, exp_vec(0), exp_vec(1));
      end
    end
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; SET_TIME = 1'b0; HRS_BTN = 1'b0; MINS_BTN = 1'b0;
    model_reset();
    test_reset();
    test_noon_and_one();
    test_midnight();
    test_set_minutes();
    test_both_buttons();
    test_enable_hold();
    test_reset_mid_set();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
